// File: rtl/image_pkg.sv
// -----------------------------------------------------------------------------
// image_pkg
// Shared definitions for the 3x3 window front end of the convolution datapath.
//   PIXEL_W  : grayscale pixel width
//   WIN_DIM  : window edge length
//   WIN_SIZE : pixels per window
//   pixel_t  : one unsigned pixel
//   win_state_t : window generator sequencing states
// -----------------------------------------------------------------------------
package image_pkg;

  localparam int PIXEL_W  = 8;
  localparam int WIN_DIM  = 3;
  localparam int WIN_SIZE = 9;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } win_state_t;

endpackage

// File: rtl/window_generator_3x3_if.sv
// -----------------------------------------------------------------------------
// window_generator_3x3_if
// Pixel stream in, 3x3 window out.
//   pixel_in / pixel_in_valid / pixel_in_sof / pixel_in_ready : raster input
//   win_1 .. win_9 / window_valid / window_ack                 : window output
//   frame_done                                                 : last window pulse
// Modport slave is the window generator; master is its environment.
// -----------------------------------------------------------------------------
interface window_generator_3x3_if;
  import image_pkg::*;

  pixel_t pixel_in;
  logic   pixel_in_valid;
  logic   pixel_in_sof;
  logic   pixel_in_ready;
  pixel_t win_1;
  pixel_t win_2;
  pixel_t win_3;
  pixel_t win_4;
  pixel_t win_5;
  pixel_t win_6;
  pixel_t win_7;
  pixel_t win_8;
  pixel_t win_9;
  logic   window_valid;
  logic   window_ack;
  logic   frame_done;

  modport slave (
    input  pixel_in, pixel_in_valid, pixel_in_sof, window_ack,
    output pixel_in_ready, window_valid, frame_done,
    output win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9
  );

  modport master (
    output pixel_in, pixel_in_valid, pixel_in_sof, window_ack,
    input  pixel_in_ready, window_valid, frame_done,
    input  win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9
  );

endinterface

// File: rtl/window_generator_3x3_line_delay.sv
// -----------------------------------------------------------------------------
// line_delay
// Enabled shift-register delay line: dout is the pixel written DEPTH enabled
// cycles earlier.
//   clk, reset (async, active-low)
//   en   : shift one position
//   din  : pixel entering the line
//   dout : pixel leaving the line
// -----------------------------------------------------------------------------
module line_delay
  import image_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  pixel_t din,
  output pixel_t dout
);

  pixel_t sr_r [DEPTH];

  // Delay line storage, shifts on every enabled cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_r[i] <= '0;
      end
    end else if (en) begin
      sr_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr_r[i] <= sr_r[i-1];
      end
    end
  end

  assign dout = sr_r[DEPTH-1];

endmodule

// File: rtl/window_generator_3x3.sv
// -----------------------------------------------------------------------------
// window_generator_3x3
// Turns a row-major 8-bit pixel stream into fully interior 3x3 windows.
// Two chained line delays supply the two rows above the incoming pixel; a
// 3x2 tap register holds the two previous columns. A window is issued for
// every transfer at row >= 2, col >= 2 and held until window_ack.
//   clk, reset (async, active-low)
//   bus : window_generator_3x3_if.slave (pixel input and window output)
// -----------------------------------------------------------------------------
module window_generator_3x3
  import image_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input logic                   clk,
  input logic                   reset,
  window_generator_3x3_if.slave bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [CW-1:0] eff_col_s;
  logic [RW-1:0] eff_row_s;
  logic          col_last_s;
  logic          row_last_s;
  logic          ready_s;
  logic          xfer_s;
  logic          emit_s;
  logic          frame_end_s;

  win_state_t    state_r;
  logic          valid_r;
  logic          done_r;
  pixel_t        win_r    [WIN_SIZE];
  pixel_t        next_win_s [WIN_SIZE];
  pixel_t        tap_r    [WIN_DIM][2];
  pixel_t        new_col_s [WIN_DIM];
  pixel_t        lb0_out_s;
  pixel_t        lb1_out_s;

  line_delay #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk   (clk),
    .reset (reset),
    .en    (xfer_s),
    .din   (bus.pixel_in),
    .dout  (lb0_out_s)
  );

  line_delay #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk   (clk),
    .reset (reset),
    .en    (xfer_s),
    .din   (lb0_out_s),
    .dout  (lb1_out_s)
  );

  // Handshake, effective raster position and emit decode.
  always_comb begin
    ready_s = !valid_r || bus.window_ack;
    xfer_s  = bus.pixel_in_valid && ready_s;
    // A start-of-frame pixel is treated as (0,0) regardless of the counters.
    if (bus.pixel_in_sof) begin
      eff_col_s = '0;
      eff_row_s = '0;
    end else begin
      eff_col_s = col_r;
      eff_row_s = row_r;
    end
    col_last_s  = (eff_col_s == CW'(IMG_WIDTH - 1));
    row_last_s  = (eff_row_s == RW'(IMG_HEIGHT - 1));
    emit_s      = xfer_s && (eff_row_s >= RW'(2)) && (eff_col_s >= CW'(2));
    frame_end_s = xfer_s && col_last_s && row_last_s;
  end

  // Window as it will look after the current pixel's column shifts in.
  always_comb begin
    new_col_s[0] = lb1_out_s;
    new_col_s[1] = lb0_out_s;
    new_col_s[2] = bus.pixel_in;
    for (int r = 0; r < WIN_DIM; r++) begin
      next_win_s[3*r]     = tap_r[r][0];
      next_win_s[3*r + 1] = tap_r[r][1];
      next_win_s[3*r + 2] = new_col_s[r];
    end
  end

  // Column / row counters advance per transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r <= '0;
      row_r <= '0;
    end else if (xfer_s) begin
      if (col_last_s) begin
        col_r <= '0;
        row_r <= row_last_s ? '0 : eff_row_s + RW'(1);
      end else begin
        col_r <= eff_col_s + CW'(1);
        row_r <= eff_row_s;
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Tap registers keep the two most recent columns of the 3-row slice.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        tap_r[r][0] <= '0;
        tap_r[r][1] <= '0;
      end
    end else if (xfer_s) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        tap_r[r][0] <= tap_r[r][1];
        tap_r[r][1] <= new_col_s[r];
      end
    end
  end

  // Sequencing FSM with registered window, valid and frame_done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FILL;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      for (int i = 0; i < WIN_SIZE; i++) begin
        win_r[i] <= '0;
      end
    end else begin
      done_r <= emit_s && frame_end_s;

      // An emitting transfer wins over an ack so windows go out back to back.
      if (emit_s) begin
        valid_r <= 1'b1;
        for (int i = 0; i < WIN_SIZE; i++) begin
          win_r[i] <= next_win_s[i];
        end
      end else if (bus.window_ack) begin
        valid_r <= 1'b0;
      end

      if (xfer_s && (bus.pixel_in_sof || frame_end_s)) begin
        state_r <= FILL;
      end else begin
        case (state_r)
          FILL:    state_r <= emit_s ? HOLD : FILL;
          STREAM:  state_r <= emit_s ? HOLD : STREAM;
          HOLD: begin
            if (emit_s) begin
              state_r <= HOLD;
            end else if (bus.window_ack) begin
              state_r <= STREAM;
            end else begin
              state_r <= HOLD;
            end
          end
          default: state_r <= FILL;
        endcase
      end
    end
  end

  assign bus.pixel_in_ready = ready_s;
  assign bus.window_valid   = valid_r;
  assign bus.frame_done     = done_r;
  assign bus.win_1          = win_r[0];
  assign bus.win_2          = win_r[1];
  assign bus.win_3          = win_r[2];
  assign bus.win_4          = win_r[3];
  assign bus.win_5          = win_r[4];
  assign bus.win_6          = win_r[5];
  assign bus.win_7          = win_r[6];
  assign bus.win_8          = win_r[7];
  assign bus.win_9          = win_r[8];

endmodule

// File: tb/tb_window_generator_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_generator_3x3
// Directed bench: a 4x4 instance and a 5x3 instance, expected windows written
// out by hand from pixel = W*row + col.
// -----------------------------------------------------------------------------
module tb_window_generator_3x3;
  import image_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  window_generator_3x3_if i4();
  window_generator_3x3_if i5();

  window_generator_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (i4)
  );

  window_generator_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (i5)
  );

  logic [71:0] exp4 [4] = '{
    {8'd0, 8'd1, 8'd2,  8'd4, 8'd5,  8'd6,  8'd8,  8'd9,  8'd10},
    {8'd1, 8'd2, 8'd3,  8'd5, 8'd6,  8'd7,  8'd9,  8'd10, 8'd11},
    {8'd4, 8'd5, 8'd6,  8'd8, 8'd9,  8'd10, 8'd12, 8'd13, 8'd14},
    {8'd5, 8'd6, 8'd7,  8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}
  };

  logic [71:0] exp5 [3] = '{
    {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12},
    {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13},
    {8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14}
  };

  logic [71:0] q4 [$];
  int          c4 [$];
  int          fd4_cnt = 0;
  int          fd4_at = 0;
  logic [71:0] q5 [$];
  int          fd5_cnt = 0;
  int          fd5_at = 0;

  function automatic logic [71:0] win4();
    return {i4.win_1, i4.win_2, i4.win_3, i4.win_4, i4.win_5,
            i4.win_6, i4.win_7, i4.win_8, i4.win_9};
  endfunction

  function automatic logic [71:0] win5();
    return {i5.win_1, i5.win_2, i5.win_3, i5.win_4, i5.win_5,
            i5.win_6, i5.win_7, i5.win_8, i5.win_9};
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle counter for back-to-back window timing.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every window the consumer takes, plus frame_done positions.
  always @(negedge clk) begin
    if (i4.window_valid && i4.window_ack) begin
      q4.push_back(win4());
      c4.push_back(cyc);
    end
    if (i4.frame_done) begin
      fd4_cnt <= fd4_cnt + 1;
      fd4_at  <= q4.size();
    end
    if (i5.window_valid && i5.window_ack) begin
      q5.push_back(win5());
    end
    if (i5.frame_done) begin
      fd5_cnt <= fd5_cnt + 1;
      fd5_at  <= q5.size();
    end
  end

  task automatic put4(input int p, input logic s);
    int t = 0;
    i4.pixel_in       = 8'(p);
    i4.pixel_in_sof   = s;
    i4.pixel_in_valid = 1'b1;
    @(negedge clk);
    while (!i4.pixel_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("put4_ready", i4.pixel_in_ready, 1);
    @(posedge clk);
    #1;
    i4.pixel_in_valid = 1'b0;
    i4.pixel_in_sof   = 1'b0;
  endtask

  task automatic put5(input int p, input logic s);
    int t = 0;
    i5.pixel_in       = 8'(p);
    i5.pixel_in_sof   = s;
    i5.pixel_in_valid = 1'b1;
    @(negedge clk);
    while (!i5.pixel_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("put5_ready", i5.pixel_in_ready, 1);
    @(posedge clk);
    #1;
    i5.pixel_in_valid = 1'b0;
    i5.pixel_in_sof   = 1'b0;
  endtask

  task automatic frame4();
    for (int i = 0; i < 16; i++) put4(i, (i == 0));
  endtask

  task automatic check_frame4(input string tag, input int qb, input int fb);
    check($sformatf("%s_count", tag), 72'(q4.size() - qb), 72'd4);
    for (int k = 0; k < 4; k++) begin
      if (qb + k < q4.size()) check($sformatf("%s_w%0d", tag, k), q4[qb+k], exp4[k]);
    end
    check($sformatf("%s_fd_cnt", tag), 72'(fd4_cnt - fb), 72'd1);
    check($sformatf("%s_fd_at", tag), 72'(fd4_at), 72'(qb + 4));
  endtask

  initial begin
    int qb;
    int fb;
    reset = 1'b0;
    i4.pixel_in = '0; i4.pixel_in_valid = 1'b0; i4.pixel_in_sof = 1'b0; i4.window_ack = 1'b1;
    i5.pixel_in = '0; i5.pixel_in_valid = 1'b0; i5.pixel_in_sof = 1'b0; i5.window_ack = 1'b1;
    #12;
    check("rst_valid", i4.window_valid, 0);
    check("rst_ready", i4.pixel_in_ready, 1);
    check("rst_done",  i4.frame_done, 0);
    check("rst_win",   win4(), 72'd0);
    @(negedge clk);
    reset = 1'b1;

    // Ack tied high: four windows, first pairs back to back.
    qb = q4.size(); fb = fd4_cnt;
    frame4();
    repeat (6) @(negedge clk);
    check_frame4("stream", qb, fb);
    if (q4.size() >= qb + 4) begin
      check("b2b_01", 72'(c4[qb+1] - c4[qb]), 72'd1);
      check("b2b_23", 72'(c4[qb+3] - c4[qb+2]), 72'd1);
    end

    // Ack held low for 10 cycles after the first window.
    qb = q4.size(); fb = fd4_cnt;
    i4.window_ack = 1'b0;
    fork
      frame4();
      begin
        int t = 0;
        @(negedge clk);
        while (!i4.window_valid && t < 60) begin
          @(negedge clk);
          t++;
        end
        check("hold_valid", i4.window_valid, 1);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("hold_win", win4(), exp4[0]);
          check("hold_ready", i4.pixel_in_ready, 0);
        end
        @(posedge clk);
        #1;
        i4.window_ack = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    check_frame4("hold", qb, fb);

    // Start of frame at row 2 col 1 restarts the frame.
    qb = q4.size(); fb = fd4_cnt;
    for (int i = 0; i < 9; i++) put4(i, (i == 0));
    frame4();
    repeat (6) @(negedge clk);
    check_frame4("sof", qb, fb);

    // Asynchronous reset while a window is held.
    i4.window_ack = 1'b0;
    for (int i = 0; i < 11; i++) put4(i, (i == 0));
    @(negedge clk);
    check("prerst_valid", i4.window_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_valid", i4.window_valid, 0);
    check("midrst_win",   win4(), 72'd0);
    check("midrst_ready", i4.pixel_in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    i4.window_ack = 1'b1;
    qb = q4.size(); fb = fd4_cnt;
    frame4();
    repeat (6) @(negedge clk);
    check_frame4("postrst", qb, fb);

    // 5x3 frame: three windows, frame_done on the third.
    qb = q5.size(); fb = fd5_cnt;
    for (int i = 0; i < 15; i++) put5(i, (i == 0));
    repeat (6) @(negedge clk);
    check("w5_count", 72'(q5.size() - qb), 72'd3);
    for (int k = 0; k < 3; k++) begin
      if (qb + k < q5.size()) check($sformatf("w5_w%0d", k), q5[qb+k], exp5[k]);
    end
    check("w5_fd_cnt", 72'(fd5_cnt - fb), 72'd1);
    check("w5_fd_at",  72'(fd5_at), 72'(qb + 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
